// File: rtl/cluster_neighbor_scan_pkg.sv
// cluster_neighbor_scan_pkg: scan state encoding and default neighbour-table address map
// Q-values are unsigned Q8.8; energies are Q2.14
package cluster_neighbor_scan_pkg;
  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_MAX_NEIGHBORS = 64;
  localparam logic [10:0] DEF_NBR_COUNT_ADDR = 11'h274;
  localparam logic [10:0] DEF_CLUSTER_BASE = 11'h0B2;
  localparam logic [10:0] DEF_QVAL_BASE = 11'h132;
  localparam logic [10:0] DEF_NBR_ID_BASE = 11'h1B2;
  localparam logic [10:0] DEF_ENERGY_BASE = 11'h032;
  localparam logic [10:0] DEF_OUT_BASE = 11'h300;
  localparam logic [15:0] DEF_NONE_ID = 16'hFFFF;
  localparam logic [15:0] DEF_ENERGY_THRESHOLD = 16'h00CD;
  typedef enum logic [3:0] {
    IDLE, WAIT_START, RD_COUNT, RD_CLUSTER, RD_ENERGY, RD_QVAL, RD_ID, WR_OUT, DONE
  } state_t;
endpackage

// File: rtl/cluster_neighbor_scan_if.sv
// cluster_neighbor_scan_if: node memory port (registered address, read data one cycle later)
interface cluster_neighbor_scan_if #(parameter int ADDR_WIDTH = 11, parameter int WORD_WIDTH = 16);
  logic [ADDR_WIDTH-1:0] address;
  logic wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic [WORD_WIDTH-1:0] data_in;
  modport master(output address, wr_en, data_out, input data_in);
  modport slave(input address, wr_en, data_out, output data_in);
endinterface

// File: rtl/cluster_neighbor_scan_addr_gen.sv
// nbr_addr_gen: byte address of entry index in a word table (stride 2)
module nbr_addr_gen #(parameter int ADDR_WIDTH = 11, parameter int INDEX_WIDTH = 16) (
  input logic [ADDR_WIDTH-1:0] base,
  input logic [INDEX_WIDTH-1:0] index,
  output logic [ADDR_WIDTH-1:0] addr
);
  assign addr = base + ADDR_WIDTH'({index, 1'b0});
endmodule

// File: rtl/cluster_neighbor_scan.sv
// cluster_neighbor_scan: in-cluster better-neighbour search writing a compacted ID list
// Optional energy pre-filter enabled by defining NBR_ENERGY_FILTER_EN
module cluster_neighbor_scan
  import cluster_neighbor_scan_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_NEIGHBORS = DEF_MAX_NEIGHBORS,
  parameter logic [ADDR_WIDTH-1:0] NBR_COUNT_ADDR = DEF_NBR_COUNT_ADDR,
  parameter logic [ADDR_WIDTH-1:0] CLUSTER_BASE = DEF_CLUSTER_BASE,
  parameter logic [ADDR_WIDTH-1:0] QVAL_BASE = DEF_QVAL_BASE,
  parameter logic [ADDR_WIDTH-1:0] NBR_ID_BASE = DEF_NBR_ID_BASE,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE = DEF_OUT_BASE,
  parameter logic [WORD_WIDTH-1:0] NONE_ID = DEF_NONE_ID
`ifdef NBR_ENERGY_FILTER_EN
  , parameter logic [ADDR_WIDTH-1:0] ENERGY_BASE = DEF_ENERGY_BASE,
  parameter logic [WORD_WIDTH-1:0] ENERGY_THRESHOLD = DEF_ENERGY_THRESHOLD
`endif
) (
  input logic clock,
  input logic nrst,
  input logic en,
  input logic start,
  input logic [WORD_WIDTH-1:0] my_cluster_id,
  input logic [WORD_WIDTH-1:0] mybest,
  cluster_neighbor_scan_if.master mem,
  output logic [WORD_WIDTH-1:0] better_count,
  output logic [WORD_WIDTH-1:0] best_value,
  output logic [WORD_WIDTH-1:0] best_neighbor_id,
  output logic [WORD_WIDTH-1:0] best_index,
  output logic busy,
  output logic overflow,
  output logic done
);
`ifdef NBR_ENERGY_FILTER_EN
  localparam state_t MATCH_STATE = RD_ENERGY;
`else
  localparam state_t MATCH_STATE = RD_QVAL;
`endif
  localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);
  state_t state, next_state, skip_state;
  logic [WORD_WIDTH-1:0] i, n, next_i, qval, nbr_id, clamped, gen_idx;
  logic [ADDR_WIDTH-1:0] gen_base, gen_addr;
  logic hold_addr;
  assign clamped = mem.data_in > MAX_N ? MAX_N : mem.data_in;
  assign skip_state = i + 1'b1 == n ? DONE : RD_CLUSTER;
  assign next_i = state == RD_COUNT ? '0 : next_state == RD_CLUSTER ? i + 1'b1 : i;
  assign hold_addr = next_state inside {IDLE, WAIT_START, DONE};
  assign busy = !(state inside {IDLE, WAIT_START, DONE});
  assign done = state == DONE;
  assign mem.wr_en = en && state == WR_OUT;
  assign mem.data_out = nbr_id;
  always_comb begin
    next_state = state;
    if (!en) next_state = IDLE;
    else case (state)
      IDLE: next_state = WAIT_START;
      WAIT_START, DONE: next_state = start ? RD_COUNT : state;
      RD_COUNT: next_state = clamped == '0 ? DONE : RD_CLUSTER;
      RD_CLUSTER: next_state = mem.data_in == my_cluster_id ? MATCH_STATE : skip_state;
`ifdef NBR_ENERGY_FILTER_EN
      RD_ENERGY: next_state = mem.data_in < ENERGY_THRESHOLD ? skip_state : RD_QVAL;
`endif
      RD_QVAL: next_state = mem.data_in > mybest ? RD_ID : skip_state;
      RD_ID: next_state = WR_OUT;
      WR_OUT: next_state = skip_state;
      default: next_state = IDLE;
    endcase
  end
  // address for the state being entered, so data_in is valid while in it
  always_comb begin
    gen_base = NBR_COUNT_ADDR;
    gen_idx = next_i;
    case (next_state)
      RD_CLUSTER: gen_base = CLUSTER_BASE;
`ifdef NBR_ENERGY_FILTER_EN
      RD_ENERGY: gen_base = ENERGY_BASE;
`endif
      RD_QVAL: gen_base = QVAL_BASE;
      RD_ID: gen_base = NBR_ID_BASE;
      WR_OUT: begin
        gen_base = OUT_BASE;
        gen_idx = better_count;
      end
      default: gen_idx = '0;
    endcase
  end
  nbr_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .INDEX_WIDTH(WORD_WIDTH)) u_addr_gen (
    .base(gen_base), .index(gen_idx), .addr(gen_addr)
  );
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      i <= '0;
      n <= '0;
      qval <= '0;
      nbr_id <= '0;
      mem.address <= '0;
      better_count <= '0;
      best_value <= '0;
      best_neighbor_id <= NONE_ID;
      best_index <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      i <= next_i;
      if (!hold_addr) mem.address <= gen_addr;
      if (en) begin
        if (next_state == RD_COUNT) begin
          best_value <= mybest;
          best_neighbor_id <= NONE_ID;
          best_index <= '0;
          better_count <= '0;
          overflow <= 1'b0;
        end
        if (state == RD_COUNT) begin
          n <= clamped;
          overflow <= mem.data_in > MAX_N;
        end
        if (state == RD_QVAL) qval <= mem.data_in;
        if (state == RD_ID) begin
          nbr_id <= mem.data_in;
          if (qval > best_value) begin
            best_value <= qval;
            best_neighbor_id <= mem.data_in;
            best_index <= i;
          end
        end
        if (state == WR_OUT) better_count <= better_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cluster_neighbor_scan.sv
// tb_cluster_neighbor_scan: randomized scoreboard bench against a loop-level reference model
module tb_cluster_neighbor_scan;
  logic clock = 0, nrst = 0, en = 0, start = 0;
  logic [15:0] my_cluster_id = 0, mybest = 0;
  logic [15:0] better_count, best_value, best_neighbor_id, best_index;
  logic busy, overflow, done;
  cluster_neighbor_scan_if bus();
  cluster_neighbor_scan dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .my_cluster_id(my_cluster_id), .mybest(mybest), .mem(bus),
    .better_count(better_count), .best_value(best_value),
    .best_neighbor_id(best_neighbor_id), .best_index(best_index),
    .busy(busy), .overflow(overflow), .done(done)
  );
  always #5 clock = ~clock;
  localparam int COUNT_W = 'h274 / 2, CL_W = 'h0B2 / 2, Q_W = 'h132 / 2;
  localparam int ID_W = 'h1B2 / 2, EN_W = 'h032 / 2;
  logic [15:0] ram [1024];
  assign bus.data_in = ram[bus.address[10:1]];
  int cl_t [64], q_t [64], id_t [64], en_t [64];
  typedef struct {int addr; int data;} wr_t;
  typedef struct {int bc; int bv; int bid; int bidx; int ovf;} res_t;
  wr_t exp_wr [$];
  res_t exp_res [$];
  int n_checks = 0, n_fail = 0, wr_seen = 0;
  bit sb_on = 1;
  logic prev_done = 0;
  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask
  always @(negedge clock) begin
    if (bus.wr_en) begin
      wr_seen++;
      if (sb_on) begin
        if (exp_wr.size() == 0) flag("unexpected_wr");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", int'(bus.address), w.addr);
          check("wr_data", int'(bus.data_out), w.data);
        end
      end
    end
    if (done && !prev_done && sb_on) begin
      if (exp_res.size() == 0) flag("unexpected_done");
      else begin
        res_t r;
        r = exp_res.pop_front();
        check("better_count", int'(better_count), r.bc);
        check("best_value", int'(best_value), r.bv);
        check("best_neighbor_id", int'(best_neighbor_id), r.bid);
        check("best_index", int'(best_index), r.bidx);
        check("overflow", int'(overflow), r.ovf);
        check("writes_missing", exp_wr.size(), 0);
      end
    end
    prev_done = done;
  end
  task automatic set_entry(input int k, input int c, input int q, input int id, input int e);
    cl_t[k] = c; q_t[k] = q; id_t[k] = id; en_t[k] = e;
    ram[CL_W + k] = 16'(c);
    ram[Q_W + k] = 16'(q);
    ram[ID_W + k] = 16'(id);
    ram[EN_W + k] = 16'(e);
  endtask
  task automatic fill_random(input int ncl);
    for (int k = 0; k < 64; k++)
      set_entry(k, int'($urandom_range(0, ncl)), int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 65535)), int'($urandom_range('h00C8, 'h00D2)));
  endtask
  // expected writes/results straight from the selection rules; cyc counts one cycle per word touched
  task automatic push_model(input int cnt, input int mc, input int mb, output int cyc);
    int n, bc, bv, bid, bidx;
    n = cnt > 64 ? 64 : cnt;
    bc = 0; bv = mb; bid = 'hFFFF; bidx = 0;
    cyc = 1;
    for (int k = 0; k < n; k++) begin
      cyc++;
      if (cl_t[k] != mc) continue;
`ifdef NBR_ENERGY_FILTER_EN
      cyc++;
      if (en_t[k] < 'h00CD) continue;
`endif
      cyc++;
      if (q_t[k] <= mb) continue;
      cyc += 2;
      exp_wr.push_back('{addr: 'h300 + 2 * bc, data: id_t[k]});
      bc++;
      if (q_t[k] > bv) begin
        bv = q_t[k]; bid = id_t[k]; bidx = k;
      end
    end
    exp_res.push_back('{bc: bc, bv: bv, bid: bid, bidx: bidx, ovf: int'(cnt > 64)});
  endtask
  task automatic run_scan(input int cnt, input int mc, input int mb);
    int cyc, k;
    ram[COUNT_W] = 16'(cnt);
    my_cluster_id = 16'(mc);
    mybest = 16'(mb);
    push_model(cnt, mc, mb, cyc);
    start = 1;
    @(posedge clock); #1 start = 0;
    k = 0;
    while (!done && k < 1000) begin
      @(posedge clock); #1;
      k++;
    end
    check("scan_cycles", k, cyc);
    @(posedge clock); #1;
  endtask
  task automatic check_reset_vals();
    check("rst_better_count", int'(better_count), 0);
    check("rst_best_value", int'(best_value), 0);
    check("rst_best_neighbor_id", int'(best_neighbor_id), 'hFFFF);
    check("rst_best_index", int'(best_index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_address", int'(bus.address), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int w0, w1, k;
    for (int a = 0; a < 1024; a++) ram[a] = '0;
    for (int a = 0; a < 64; a++) set_entry(a, 0, 0, 0, 'hFFFF);
    repeat (2) @(posedge clock);
    #1 check_reset_vals();
    nrst = 1; en = 1;
    repeat (2) @(posedge clock);
    #1;
    run_scan(0, 3, 'h0100);
    set_entry(0, 3, 'h0180, 'h11, 'hFFFF);
    set_entry(1, 5, 'h0300, 'h12, 'hFFFF);
    set_entry(2, 3, 'h0080, 'h13, 'hFFFF);
    set_entry(3, 3, 'h0180, 'h14, 'hFFFF);
    run_scan(4, 3, 'h0100);
    check("dir_better_count", int'(better_count), 2);
    check("dir_best_value", int'(best_value), 'h0180);
    check("dir_best_id", int'(best_neighbor_id), 'h11);
    check("dir_best_index", int'(best_index), 0);
`ifdef NBR_ENERGY_FILTER_EN
    set_entry(0, 1, 'h0200, 'h21, 'h00CC);
    set_entry(1, 1, 'h0200, 'h22, 'h00CD);
    run_scan(2, 1, 'h0100);
    check("energy_count", int'(better_count), 1);
    check("energy_best_id", int'(best_neighbor_id), 'h22);
`endif
    fill_random(1);
    run_scan(100, 1, 'h4000);
    check("ovf_flag", int'(overflow), 1);
    fill_random(1);
    run_scan(64, 0, 'h2000);
    check("no_ovf_at_64", int'(overflow), 0);
    repeat (20) begin
      fill_random(int'($urandom_range(0, 3)));
      run_scan(int'($urandom_range(0, 70)), int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
    end
    for (int a = 0; a < 64; a++) set_entry(a, 2, 'h8000 + a, 'h40 + a, 'hFFFF);
    sb_on = 0;
    ram[COUNT_W] = 16'd20;
    my_cluster_id = 16'd2;
    mybest = 16'd0;
    w0 = wr_seen;
    start = 1;
    @(posedge clock); #1 start = 0;
    k = 0;
    while (wr_seen < w0 + 3 && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    en = 0;
    w1 = wr_seen;
    @(posedge clock); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (10) @(posedge clock);
    #1;
    check("abort_no_wr", wr_seen - w1, 0);
    check("abort_partial_count", int'(better_count), 3);
    en = 1;
    repeat (2) @(posedge clock);
    #1;
    start = 1;
    @(posedge clock); #1 start = 0;
    k = 0;
    while (!bus.wr_en && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    check("rst_reach_wr", int'(bus.wr_en), 1);
    #2 nrst = 0;
    #1 check_reset_vals();
    @(posedge clock); #1 nrst = 1;
    repeat (3) @(posedge clock);
    #1 sb_on = 1;
    fill_random(1);
    run_scan(30, 1, 'h3000);
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_res_drained", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cluster_neighbor_scan.md
Name: cluster_neighbor_scan

Overview:
Parametrised, multi-mode successor to the per-cluster better-neighbour search used by the EER-RL cluster-head routing logic. After a start pulse it walks the neighbour table in node memory and keeps only entries whose cluster ID matches the node's own cluster. Among those it finds every neighbour whose Q-value beats the node's own best, writes their IDs as a compacted list back to memory, and reports the count, the best Q-value and the best neighbour ID. It sits between the memory arbiter and the routing/next-hop decision logic.

Parameters:
WORD_WIDTH, 16, data/Q-value width (Q-values unsigned Q8.8)
ADDR_WIDTH, 11, byte address width (words at even addresses, stride 2)
MAX_NEIGHBORS, 64, table depth; neighbour count clamps to this
NBR_COUNT_ADDR, 11'h274, address of neighbour count word
CLUSTER_BASE, 11'h0B2, base of neighbour cluster-ID array
QVAL_BASE, 11'h132, base of neighbour Q-value array
NBR_ID_BASE, 11'h1B2, base of neighbour node-ID array
ENERGY_BASE, 11'h032, base of neighbour energy array (Q2.14)
OUT_BASE, 11'h300, base of written better-neighbour ID list
NONE_ID, 16'hFFFF, best_neighbor_id value when no neighbour qualifies
ENERGY_THRESHOLD, 16'h00CD, minimum neighbour energy (optional feature only)

Ports:
clock in 1 system clock, rising edge
nrst in 1 asynchronous active-low reset
en in 1 block enable; low forces IDLE
start in 1 begin scan (sampled in WAIT_START/DONE)
my_cluster_id in WORD_WIDTH own cluster ID
mybest in WORD_WIDTH own best Q-value, Q8.8
data_in in WORD_WIDTH memory read data, valid one cycle after address
address out ADDR_WIDTH registered memory byte address
wr_en out 1 memory write strobe, one cycle per word
data_out out WORD_WIDTH memory write data
better_count out WORD_WIDTH number of better in-cluster neighbours
best_value out WORD_WIDTH highest qualifying Q-value (else mybest)
best_neighbor_id out WORD_WIDTH node ID of best neighbour (else NONE_ID)
best_index out WORD_WIDTH table index of best neighbour (else 0)
busy out 1 high from start accept until DONE
overflow out 1 sticky per scan: table count exceeded MAX_NEIGHBORS
done out 1 high while in DONE

Behaviour:
- Reset (async, nrst low): all outputs 0 except best_value=0, best_neighbor_id=NONE_ID; state IDLE; index i=0.
- FSM: IDLE -> (en) WAIT_START -> (start) RD_COUNT -> RD_CLUSTER -> [RD_ENERGY] -> RD_QVAL -> RD_ID -> WR_OUT -> next i ... -> DONE.
- Each read state drives address in the previous state; data_in is captured the cycle after. One word per cycle; no wait states.
- RD_COUNT: n = min(data_in, MAX_NEIGHBORS); overflow=1 if clamped. n=0 -> DONE directly.
- RD_CLUSTER: address CLUSTER_BASE+2i. Mismatch with my_cluster_id -> skip entry (i+1, or DONE if i+1==n).
- RD_QVAL: address QVAL_BASE+2i. Better iff qValue > mybest (unsigned strict). Otherwise skip.
- RD_ID: read NBR_ID_BASE+2i. If qValue > best_value, update best_value, best_neighbor_id and best_index. Ties keep the earlier index.
- WR_OUT: wr_en=1, address=OUT_BASE+2*better_count, data_out=ID; better_count increments after the write.
- Scan start initialises best_value=mybest, best_neighbor_id=NONE_ID, better_count=0, overflow=0.
- Results are updated live; they are valid only when done=1.
- DONE: done=1, busy=0. start re-runs the scan. en low -> IDLE.
- en low mid-scan: abort to IDLE next cycle; wr_en=0, done=0; partial results retained.
- start while busy: ignored. Async reset mid-scan: immediate return to reset values.
- Worst-case latency: 2 + 4n cycles (5n with energy filter) + 1.

Optional Feature:
NBR_ENERGY_FILTER_EN defined:
- RD_ENERGY is inserted after a cluster match, reading ENERGY_BASE+2i.
- A neighbour with energy < ENERGY_THRESHOLD is skipped before the Q-value read.

NBR_ENERGY_FILTER_EN undefined:
- No RD_ENERGY state and no energy reads.
- ENERGY_THRESHOLD is unused.

Decomposition:
- Shared package: FSM state encoding, default address-map constants, NONE_ID, the Q8.8/Q2.14 format notes.
- One natural sub-module, nbr_addr_gen: combinational base+2*index address generator, reused by sibling table-walking blocks.

Test Plan:
- n=0 -> done after RD_COUNT; better_count=0, best_value=mybest, best_neighbor_id=16'hFFFF, no wr_en.
- n=4, clusters {3,5,3,3}, my_cluster_id=3, Q {0x0180,0x0300,0x0080,0x0180}, mybest=0x0100, IDs {0x11,0x12,0x13,0x14} -> better_count=2; OUT_BASE gets 0x11 then 0x14; best_value=0x0180; best_neighbor_id=0x11 (tie keeps first); best_index=0.
- Count word=100 -> overflow=1; exactly 64 entries scanned.
- en dropped mid-scan -> IDLE next cycle; done=0; no further wr_en.
- nrst pulsed during WR_OUT -> outputs return to reset values asynchronously.
- With NBR_ENERGY_FILTER_EN: the qualifying entry with energy 0x00CC is excluded and the one with 0x00CD is included.
